// File: rtl/mac_operand_streamer.sv
// Operand burst source for the MAC control FSM: buffers host words, then presents
// mode, a valid-qualified stream with a last marker, and waits for done or times out.
module mac_operand_streamer #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 8,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   start,
    input  logic                   start_mode,
    input  logic                   mac_done,
    output logic                   mac_mode,
    output logic                   mac_valid,
    output logic                   mac_last,
    output logic [DATA_W-1:0]      mac_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ARM, STREAM, WAIT_DONE} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr, rd_ptr_inc;
    logic [TW-1:0]     timer, timer_n;
    logic [CW-1:0]     count_n;
    logic              wr_ok, start_ok, pop;
    logic              mode_n, valid_n, last_n, done_n, terr_n;
    logic [DATA_W-1:0] data_n;

    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign wr_ok      = (state == IDLE) && load_en && !full;
    assign start_ok   = (state == IDLE) && start && ((count != '0) || wr_ok);

    // Output registers are loaded one cycle ahead: the word shown during a STREAM
    // cycle is the head of the buffer, and it is popped at the end of that cycle.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        mode_n  = mac_mode;
        valid_n = 1'b0;
        last_n  = 1'b0;
        data_n  = '0;
        done_n  = 1'b0;
        terr_n  = timeout_err;
        timer_n = timer;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_n = ARM;
                    mode_n  = start_mode;
                    terr_n  = 1'b0;
                end
            end
            ARM: begin
                state_n = STREAM;
                valid_n = 1'b1;
                data_n  = mem[rd_ptr];
                last_n  = (count == CW'(1));
            end
            STREAM: begin
                pop = 1'b1;
                if (count <= CW'(1)) begin
                    state_n = WAIT_DONE;
                    timer_n = '0;
                end else begin
                    valid_n = 1'b1;
                    data_n  = mem[rd_ptr_inc];
                    last_n  = (count == CW'(2));
                end
            end
            WAIT_DONE: begin
                if (mac_done) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (timer == TW'(DONE_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    terr_n  = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        count_n = count;
        if (wr_ok)
            count_n = count + CW'(1);
        else if (pop)
            count_n = count - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            timer       <= '0;
            busy        <= 1'b0;
            mac_mode    <= 1'b0;
            mac_valid   <= 1'b0;
            mac_last    <= 1'b0;
            mac_data    <= '0;
            burst_done  <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_n;
            if (wr_ok) begin
                mem[wr_ptr] <= load_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr_inc;
            count       <= count_n;
            full        <= (count_n == CW'(DEPTH));
            timer       <= timer_n;
            busy        <= (state_n != IDLE);
            mac_mode    <= mode_n;
            mac_valid   <= valid_n;
            mac_last    <= last_n;
            mac_data    <= data_n;
            burst_done  <= done_n;
            timeout_err <= terr_n;
        end
    end
endmodule

// File: tb/tb_mac_operand_streamer.sv
// Randomized bench for mac_operand_streamer; a queue-based model predicts every
// observable output cycle by cycle from burst-level rules.
module tb_mac_operand_streamer;
    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int DT  = 16;
    localparam int CW  = $clog2(DEP) + 1;

    logic          clk = 1'b0, reset = 1'b0;
    logic          load_en = 1'b0, start = 1'b0, start_mode = 1'b0, mac_done = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          mac_mode, mac_valid, mac_last, busy, full, burst_done, timeout_err;
    logic [DW-1:0] mac_data;
    logic [CW-1:0] count;

    int            n_cmp = 0, n_fail = 0;
    logic [DW-1:0] q[$];
    logic          m_mode = 1'b0, m_terr = 1'b0;

    always #5 clk = ~clk;

    mac_operand_streamer #(.DATA_W(DW), .DEPTH(DEP), .DONE_TIMEOUT(DT)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
        .start(start), .start_mode(start_mode), .mac_done(mac_done),
        .mac_mode(mac_mode), .mac_valid(mac_valid), .mac_last(mac_last),
        .mac_data(mac_data), .count(count), .full(full), .busy(busy),
        .burst_done(burst_done), .timeout_err(timeout_err)
    );

    typedef logic [DW+CW+6:0] snap_t;

    function automatic snap_t act();
        return {busy, mac_valid, mac_last, mac_data, mac_mode, count, full, burst_done, timeout_err};
    endfunction

    function automatic snap_t mk(logic b, logic v, logic l, logic [DW-1:0] d, logic m,
                                 int c, logic bd, logic te);
        return {b, v, l, d, m, CW'(c), (c == DEP), bd, te};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] d);
        snap_t e;
        load_en = 1'b1; load_data = d;
        tick();
        load_en = 1'b0;
        if (q.size() < DEP) q.push_back(d);
        e = mk(0, 0, 0, '0, m_mode, q.size(), 0, m_terr);
        n_cmp++;
        if (act() !== e) begin
            n_fail++; $display("FAIL load: got %h want %h", act(), e);
        end
    endtask

    // done_at = 0 -> never assert mac_done; otherwise pulse it in WAIT_DONE cycle done_at
    task automatic burst(input logic mode, input int done_at, input bit noise,
                         input bit with_load, input logic [DW-1:0] ld);
        logic [DW-1:0] exp[$];
        snap_t e;
        int n;
        start = 1'b1; start_mode = mode;
        if (with_load) begin
            load_en = 1'b1; load_data = ld;
            if (q.size() < DEP) q.push_back(ld);
        end
        tick();
        start = 1'b0; load_en = 1'b0;
        if (q.size() == 0) begin
            e = mk(0, 0, 0, '0, m_mode, 0, 0, m_terr);
            n_cmp++;
            if (act() !== e) begin
                n_fail++; $display("FAIL start_ignored: got %h want %h", act(), e);
            end
            return;
        end
        exp = q; q.delete(); m_mode = mode; m_terr = 1'b0;
        n = exp.size();
        e = mk(1, 0, 0, '0, mode, n, 0, 0);
        n_cmp++;
        if (act() !== e) begin
            n_fail++; $display("FAIL arm: got %h want %h", act(), e);
        end
        for (int i = 0; i < n; i++) begin
            if (noise) begin
                start = 1'b1; start_mode = ~mode; load_en = 1'b1;
                load_data = DW'($urandom); mac_done = 1'b1;
            end
            tick();
            e = mk(1, 1, (i == n - 1), exp[i], mode, n - i, 0, 0);
            n_cmp++;
            if (act() !== e) begin
                n_fail++; $display("FAIL beat%0d: got %h want %h", i, act(), e);
            end
        end
        start = 1'b0; load_en = 1'b0; mac_done = 1'b0;
        for (int k = 1; k <= ((done_at == 0) ? DT : done_at); k++) begin
            tick();
            e = mk(1, 0, 0, '0, mode, 0, 0, 0);
            n_cmp++;
            if (act() !== e) begin
                n_fail++; $display("FAIL wait%0d: got %h want %h", k, act(), e);
            end
        end
        if (done_at == 0) begin
            tick();
            m_terr = 1'b1;
            e = mk(0, 0, 0, '0, mode, 0, 0, 1);
            n_cmp++;
            if (act() !== e) begin
                n_fail++; $display("FAIL timeout: got %h want %h", act(), e);
            end
        end else begin
            mac_done = 1'b1;
            tick();
            mac_done = 1'b0;
            e = mk(0, 0, 0, '0, mode, 0, 1, 0);
            n_cmp++;
            if (act() !== e) begin
                n_fail++; $display("FAIL done: got %h want %h", act(), e);
            end
            tick();
            e = mk(0, 0, 0, '0, mode, 0, 0, 0);
            n_cmp++;
            if (act() !== e) begin
                n_fail++; $display("FAIL done_pulse: got %h want %h", act(), e);
            end
        end
    endtask

    task automatic test_reset();
        snap_t e;
        #2;
        e = mk(0, 0, 0, '0, 0, 0, 0, 0);
        n_cmp++;
        if (act() !== e) begin
            n_fail++; $display("FAIL reset: got %h want %h", act(), e);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load(8'h11); load(8'h22); load(8'h33);
        burst(1'b0, 3, 0, 0, '0);
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i <= DEP; i++) load(DW'($urandom));
        burst(1'b1, $urandom_range(1, DT), 0, 0, '0);
        for (int i = 0; i < DEP; i++) load(DW'($urandom));
        burst(1'b0, $urandom_range(1, DT), 0, 0, '0);
    endtask

    task automatic test_start_empty();
        burst(1'b1, 1, 0, 0, '0);
        burst(1'b1, 2, 0, 1, 8'hA5);
    endtask

    task automatic test_timeout();
        load(DW'($urandom)); load(DW'($urandom));
        burst(1'b0, 0, 0, 0, '0);
        load(DW'($urandom));
        burst(1'b1, 1, 0, 0, '0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) load(DW'($urandom));
        burst(1'b1, DT, 1, 0, '0);
        load(DW'($urandom));
        burst(1'b0, 1, 1, 1, DW'($urandom));
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int nl;
            nl = $urandom_range(0, DEP + 2);
            for (int i = 0; i < nl; i++) load(DW'($urandom));
            burst(1'($urandom), $urandom_range(0, DT), 1'($urandom), 1'($urandom), DW'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        snap_t e;
        for (int i = 0; i < 5; i++) load(DW'($urandom));
        start = 1'b1; start_mode = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        q.delete(); m_mode = 1'b0; m_terr = 1'b0;
        e = mk(0, 0, 0, '0, 0, 0, 0, 0);
        n_cmp++;
        if (act() !== e) begin
            n_fail++; $display("FAIL reset_mid: got %h want %h", act(), e);
        end
        tick();
        reset = 1'b1;
        tick();
        burst(1'b1, 1, 0, 0, '0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_start_empty();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
